mac_scheduler: RTL and testbench

- Time-multiplexes one signed BITSIZE×BITSIZE multiplier (one iCE40 SB_MAC16) between up to NREQ audio datapath blocks.
- Requesters are the envelope VCA, modulator, biquad and echo gain stages.
- Grants are round-robin; the product is returned in Q1.15-style fixed point with rounding and optional saturation.
- Sits between the matrix-routed audio blocks and the shared DSP tile and runs on the fast system clock. One sample period is more than 1000 clocks, so the throughput of one multiply per clock is ample.

---
 rtl/audio_pkg.sv | 32 +++
 rtl/mac_pipe.sv | 63 ++++++
 rtl/mac_scheduler.sv | 107 ++++++++++
 tb/tb_mac_scheduler.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and fixed-point helpers for the audio datapath.
//   AUDIO_BITSIZE / AUDIO_NREQ : default operand width and requester count
//   ROUND_BIAS                 : half-LSB bias for Q1.(BITSIZE-1) rounding
//   round_shift()              : round a full-width product back to BITSIZE
//                                fractional bits, optionally saturating
package audio_pkg;

  localparam int AUDIO_BITSIZE = 16;
  localparam int AUDIO_NREQ    = 4;
  localparam int ROUND_BIAS    = 2 ** (AUDIO_BITSIZE - 2);

  // Widest operand the helper supports; the product plus bias is kept one
  // bit wider than 2*MAXW so the add never overflows.
  localparam int MAXW = 32;
  typedef logic signed [2*MAXW:0] wide_t;

  // r = (p + 2^(bs-2)) >>> (bs-1); with sat set, clamp to the signed bs-bit
  // range. Caller truncates the return value to bs bits, which gives the
  // two's-complement wrap when sat is clear.
  function automatic logic signed [MAXW-1:0] round_shift(input wide_t p,
                                                         input int    bs,
                                                         input logic  sat);
    wide_t r, hi, lo;
    r  = (p + (wide_t'(1) <<< (bs - 2))) >>> (bs - 1);
    hi = (wide_t'(1) <<< (bs - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (bs - 1));
    if (sat && (r > hi))      r = hi;
    else if (sat && (r < lo)) r = lo;
    return r[MAXW-1:0];
  endfunction

endpackage

// File: rtl/mac_pipe.sv
// mac_pipe: stages 2 and 3 of the shared multiplier.
//   stage 2 : signed BITSIZE x BITSIZE product (maps onto SB_MAC16)
//   stage 3 : round to Q1.(BITSIZE-1), saturate or wrap, register result
// Ports: clk, rst (async high); vld_i/id_i/a_i/b_i from stage 1;
//        vld_o/id_o/result_o stage-3 outputs (result held when idle).
// Config macro: MAC_SCHED_SAT_EN selects saturation instead of wrap.
module mac_pipe
  import audio_pkg::*;
#(
  parameter int BITSIZE = AUDIO_BITSIZE,
  parameter int IDW     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vld_i,
  input  logic [IDW-1:0]            id_i,
  input  logic signed [BITSIZE-1:0] a_i,
  input  logic signed [BITSIZE-1:0] b_i,
  output logic                      vld_o,
  output logic [IDW-1:0]            id_o,
  output logic [BITSIZE-1:0]        result_o
);

`ifdef MAC_SCHED_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  typedef logic signed [BITSIZE-1:0] res_t;

  logic [3:2]                 vld_pipe_q;
  logic [IDW-1:0]             id2_q, id3_q;
  logic signed [2*BITSIZE-1:0] prod_q;
  res_t                       res_q, res_d;

  always_comb res_d = res_t'(round_shift(wide_t'(prod_q), BITSIZE, SAT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      id2_q      <= '0;
      id3_q      <= '0;
      prod_q     <= '0;
      res_q      <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[2], vld_i};
      if (vld_i) begin
        prod_q <= a_i * b_i;
        id2_q  <= id_i;
      end
      if (vld_pipe_q[2]) begin
        res_q <= res_d;
        id3_q <= id2_q;
      end
    end
  end

  assign vld_o    = vld_pipe_q[3];
  assign id_o     = id3_q;
  assign result_o = res_q;

endmodule

// File: rtl/mac_scheduler.sv
// mac_scheduler: round-robin time-multiplexing of one signed multiplier
// between NREQ audio blocks (VCA, modulator, biquad, echo gain).
//   clk, rst     : system clock, async active-high reset
//   req          : per-requester request, held until its done pulse
//   op_a, op_b   : flattened operands, requester k at [k*BITSIZE +: BITSIZE]
//   done         : one-cycle pulse naming the owner of `result`
//   result       : shared rounded Q1.(BITSIZE-1) product
//   busy         : any operation outstanding
// Latency grant edge -> done cycle is three register stages.
// Config macro: MAC_SCHED_SAT_EN (saturate instead of wrap, in mac_pipe).
module mac_scheduler
  import audio_pkg::*;
#(
  parameter int BITSIZE = AUDIO_BITSIZE,
  parameter int NREQ    = AUDIO_NREQ
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*BITSIZE-1:0] op_a,
  input  logic [NREQ*BITSIZE-1:0] op_b,
  output logic [NREQ-1:0]         done,
  output logic [BITSIZE-1:0]      result,
  output logic                    busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0][BITSIZE-1:0] a_vec, b_vec;
  logic [NREQ-1:0]              pend, inflight_q, inflight_d, gnt_mask;
  logic [IDW-1:0]               ptr_q, ptr_d, gnt_id, idx;
  logic                         gnt_vld, arm_q;
  logic                         s1_vld_q;
  logic [IDW-1:0]               s1_id_q;
  logic [BITSIZE-1:0]           s1_a_q, s1_b_q;
  logic                         p_vld;
  logic [IDW-1:0]               p_id;

  assign a_vec = op_a;
  assign b_vec = op_b;
  assign pend  = req & ~inflight_q;

  // Rotating-priority search from ptr upward with wrap. arm_q keeps the
  // first edge after reset release from ever granting.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ((int'(ptr_q) + i) >= NREQ) ? IDW'(int'(ptr_q) + i - NREQ)
                                        : IDW'(int'(ptr_q) + i);
      if (!gnt_vld && arm_q && pend[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  assign gnt_mask = gnt_vld ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_id) : '0;
  assign done     = p_vld ? ({{(NREQ-1){1'b0}}, 1'b1} << p_id) : '0;

  // Retire on the edge that ends the done cycle, so the same requester can
  // re-win no earlier than one edge later.
  assign inflight_d = (inflight_q & ~done) | gnt_mask;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      inflight_q <= '0;
      arm_q      <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_id_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      arm_q      <= 1'b1;
      s1_vld_q   <= gnt_vld;
      if (gnt_vld) begin
        s1_id_q <= gnt_id;
        s1_a_q  <= a_vec[gnt_id];
        s1_b_q  <= b_vec[gnt_id];
      end
    end
  end

  mac_pipe #(.BITSIZE(BITSIZE), .IDW(IDW)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .vld_i    (s1_vld_q),
    .id_i     (s1_id_q),
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .vld_o    (p_vld),
    .id_o     (p_id),
    .result_o (result)
  );

  assign busy = |inflight_q;

endmodule

// File: tb/tb_mac_scheduler.sv
module tb_mac_scheduler;

  logic        clk, rst;
  logic [3:0]  req;
  logic [63:0] op_a, op_b;
  logic [3:0]  done;
  logic [15:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mac_scheduler #(.BITSIZE(16), .NREQ(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .op_a   (op_a),
    .op_b   (op_b),
    .done   (done),
    .result (result),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MAC_SCHED_SAT_EN
  localparam logic [15:0] SAT_EXP = 16'h7FFF;
`else
  localparam logic [15:0] SAT_EXP = 16'h8000;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setop(input int k, input logic [15:0] a, input logic [15:0] b);
    op_a[k*16 +: 16] = a;
    op_b[k*16 +: 16] = b;
  endtask

  function automatic logic [3:0] oh(input int k);
    logic [3:0] m;
    m = 4'b0001 << k;
    return m;
  endfunction

  // Single isolated operation: grant on the first edge, done on the third
  // negedge after req rises, then idle.
  task automatic op1(input int k, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] exp, input string tag);
    setop(k, a, b);
    req[k] = 1'b1;
    @(negedge clk); chk({tag, " busy"}, busy, 1);  chk({tag, " early1"}, done, 0);
    @(negedge clk); chk({tag, " early2"}, done, 0);
    @(negedge clk); chk({tag, " done"}, done, oh(k)); chk({tag, " result"}, result, exp);
    req[k] = 1'b0;
    @(negedge clk); chk({tag, " after"}, done, 0);  chk({tag, " idle"}, busy, 0);
  endtask

  logic [15:0] fexp [4];

  initial begin
    rst = 1'b1; req = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk("rst done", done, 0); chk("rst result", result, 0); chk("rst busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Arithmetic / rounding / saturation on isolated operations
    op1(0, 16'h4000, 16'h4000, 16'h2000, "half*half");
    op1(1, 16'h0001, 16'h4000, 16'h0001, "round up");
    op1(2, 16'hFFFF, 16'h3FFF, 16'h0000, "round neg");
    op1(0, 16'h8000, 16'h4000, 16'hC000, "neg exact");
    op1(1, 16'hFFFF, 16'h4001, 16'hFFFF, "neg -1lsb");
    op1(3, 16'h8000, 16'h8000, SAT_EXP,  "sat corner");

    // Fairness: all four held; ptr is 0 here
    setop(0, 16'h2000, 16'h2000); fexp[0] = 16'h0800;
    setop(1, 16'h7FFF, 16'h7FFF); fexp[1] = 16'h7FFE;
    setop(2, 16'h8000, 16'h7FFF); fexp[2] = 16'h8001;
    setop(3, 16'hC000, 16'h4000); fexp[3] = 16'hE000;
    req = 4'hF;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j == 1) chk("rr busy", busy, 1);
      if (j >= 3) begin
        chk($sformatf("rr done %0d", j), done, oh((j - 3) % 4));
        chk($sformatf("rr result %0d", j), result, fexp[(j - 3) % 4]);
      end
      if (j == 10) req = 4'h0;
    end
    @(negedge clk);
    chk("rr drained busy", busy, 0); chk("rr drained done", done, 0);

    // Back-to-back on requester 2, then ptr must sit at 3
    setop(2, 16'h4000, 16'h2000);
    req = 4'b0100;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      case (j)
        3:  begin chk("b2b first", done, 4'b0100); chk("b2b first res", result, 16'h1000); end
        4, 5, 6: chk($sformatf("b2b gap %0d", j), done, 0);
        7:  begin
              chk("b2b second", done, 4'b0100); chk("b2b second res", result, 16'h1000);
              setop(1, 16'h4000, 16'h4000); setop(3, 16'h0001, 16'h4000);
              req = 4'b1010;
            end
        10: begin chk("ptr first 3", done, 4'b1000); chk("ptr res 3", result, 16'h0001); req[3] = 1'b0; end
        11: begin chk("ptr then 1", done, 4'b0010); chk("ptr res 1", result, 16'h2000); req[1] = 1'b0; end
        12: chk("ptr idle", done, 0);
        default: ;
      endcase
    end

    // Reset one clock after a grant: op lost, ptr back to 0
    setop(0, 16'h4000, 16'h4000);
    req = 4'b0001;
    @(negedge clk); chk("mid busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("in rst busy", busy, 0); chk("in rst done", done, 0); chk("in rst result", result, 0);
    setop(0, 16'h7FFF, 16'h7FFF); setop(1, 16'h8000, 16'h7FFF);
    req = 4'b0011;
    @(negedge clk); chk("in rst done2", done, 0);
    rst = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j <= 3) chk($sformatf("post rst quiet %0d", j), done, 0);
      if (j == 4) begin chk("post rst 0", done, 4'b0001); chk("post rst res0", result, 16'h7FFE); req[0] = 1'b0; end
      if (j == 5) begin chk("post rst 1", done, 4'b0010); chk("post rst res1", result, 16'h8001); req[1] = 1'b0; end
    end
    @(negedge clk);
    chk("final busy", busy, 0); chk("final done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
